// File: rtl/dma_apb_pkg.sv
// rtl/dma_apb_pkg.sv - Shared types and widths for the DMA APB configuration requester
//
// Contents:
//   DMA_APB_ADDR_W / DMA_APB_DATA_W : widths of the DMA APB configuration port
//   apb_state_e                     : requester FSM states
//   rsp_status_e                    : 2-bit response status codes
//   is_word_aligned()               : true when a byte address sits on a 32-bit boundary

package dma_apb_pkg;

  localparam int DMA_APB_ADDR_W = 13;
  localparam int DMA_APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    RSP_OK         = 2'b00,
    RSP_SLVERR     = 2'b01,
    RSP_TIMEOUT    = 2'b10,
    RSP_MISALIGNED = 2'b11
  } rsp_status_e;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dma_apb_cfg_master_if.sv
// rtl/dma_apb_cfg_master_if.sv - Command, response and APB signal bundle for dma_apb_cfg_master
//
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command channel (source -> requester)
//   rsp_valid/rsp_ready/rsp_rdata/rsp_status         : response channel (requester -> source)
//   pclken                                           : APB clock enable
//   psel/penable/pwrite/paddr/pwdata                 : APB request pins (requester -> DMA)
//   prdata/pready/pslverr                            : APB completer response (DMA -> requester)
// Modports:
//   master : the requester
//   slave  : the command source together with the APB completer

interface dma_apb_cfg_master_if
  import dma_apb_pkg::*;
#(
  parameter int ADDR_W = DMA_APB_ADDR_W,
  parameter int DATA_W = DMA_APB_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_status;

  logic              pclken;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_status,
    input  rsp_ready,
    input  pclken,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_status,
    output rsp_ready,
    output pclken,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/dma_apb_cfg_master.sv
// rtl/dma_apb_cfg_master.sv - APB requester driving the DMA configuration port from a command channel
//
// Ports:
//   clk   : clock, all logic on the rising edge
//   rst   : asynchronous active-low reset
//   bus   : dma_apb_cfg_master_if.master - command, response and APB pins
//   busy  : high whenever the FSM is not in IDLE
// Parameters:
//   ADDR_W, DATA_W : APB widths
//   TIMEOUT        : enabled ACCESS cycles without pready before abort (0 = never)
//
// One command becomes one APB SETUP/ACCESS transfer. Every output is a flop,
// so there is no combinational path from any input to the APB pins.

module dma_apb_cfg_master
  import dma_apb_pkg::*;
#(
  parameter int ADDR_W  = DMA_APB_ADDR_W,
  parameter int DATA_W  = DMA_APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  dma_apb_cfg_master_if.master        bus,
  output logic                        busy
);

  // At least one bit even when the timeout is disabled.
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  apb_state_e        state_q,      state_d;
  logic              cmd_ready_q,  cmd_ready_d;
  logic              busy_q,       busy_d;
  logic              psel_q,       psel_d;
  logic              penable_q,    penable_d;
  logic              pwrite_q,     pwrite_d;
  logic [ADDR_W-1:0] paddr_q,      paddr_d;
  logic [DATA_W-1:0] pwdata_q,     pwdata_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,  rsp_rdata_d;
  rsp_status_e       rsp_status_q, rsp_status_d;
  logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= RSP_OK;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that each flop shows the value that belongs to the state being entered.
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    busy_d       = busy_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    tmo_cnt_d    = tmo_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (!is_word_aligned(bus.cmd_addr[1:0])) begin
            // Rejected without touching the APB pins; paddr/pwdata keep history.
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = '0;
            rsp_status_d = RSP_MISALIGNED;
          end else begin
            state_d   = ST_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = bus.cmd_write;
            paddr_d   = bus.cmd_addr;
            pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          end
        end
      end

      ST_SETUP: begin
        if (bus.pclken) begin
          state_d   = ST_ACCESS;
          penable_d = 1'b1;
          tmo_cnt_d = '0;
        end
      end

      ST_ACCESS: begin
        // Completer signals only count on enabled cycles.
        if (bus.pclken) begin
          if (bus.pready) begin
            state_d      = ST_RESP;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_status_d = bus.pslverr ? RSP_SLVERR : RSP_OK;
            rsp_rdata_d  = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
          end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
            // This is the TIMEOUT-th enabled cycle without pready.
            state_d      = ST_RESP;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_status_d = RSP_TIMEOUT;
            rsp_rdata_d  = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_status = rsp_status_q;
  assign busy           = busy_q;

endmodule

// File: doc/dma_apb_cfg_master.md
# dma_apb_cfg_master

APB requester that drives the DMA engine's 13-bit APB configuration port from the testbench or an on-chip CPU shim. It accepts single read/write commands on a valid/ready command channel and runs one APB SETUP/ACCESS transfer per command, honouring `pclken` and `pready`. It returns read data and a 2-bit status on a valid/ready response channel. It is the initiator counterpart of the DMA's APB config completer and sits between the command source and the DMA `psel/penable/paddr/pwrite/pwdata` pins.

## Interface
- `ADDR_W`, 13, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT`, 16, max enabled ACCESS cycles without `pready` before abort; 0 disables timeout
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  byte address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors
- `rsp_status`  out  2  00 OK, 01 SLVERR, 10 TIMEOUT, 11 MISALIGNED
- `pclken`  in  1  APB clock enable; APB phases advance only when high
- `psel`, `penable`, `pwrite`  out  1  APB controls
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `prdata`  in  DATA_W  APB read data
- `pready`, `pslverr`  in  1  APB completer response
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - `cmd_ready`=1 (only in IDLE).
  - On handshake, register write/addr/wdata.
  - If `cmd_addr[1:0]`≠0: go to RESP with status MISALIGNED and no APB activity.
  - Otherwise go to SETUP.
- SETUP
  - Drive `psel`=1, `penable`=0, registered `paddr`/`pwrite`; `pwdata` = wdata for writes, 0 for reads.
  - Move to ACCESS on a cycle with `pclken`=1; otherwise hold.
- ACCESS
  - Drive `psel`=1, `penable`=1.
  - On `pclken`&`pready`: capture `prdata` for reads only; status = `pslverr` ? SLVERR : OK. On SLVERR, rdata=0. Go to RESP.
  - Timeout counter (width ≥ clog2(TIMEOUT+1)) clears on entry and increments on each `pclken` cycle with `pready`=0. When it reaches TIMEOUT (TIMEOUT≠0), go to RESP with status TIMEOUT and rdata 0.
- RESP
  - `psel`=`penable`=0, `rsp_valid`=1; `rsp_rdata`/`rsp_status` held stable until `rsp_ready`, then return to IDLE.
- `pready`/`pslverr`/`prdata` are ignored outside ACCESS, and in ACCESS on `pclken`=0 cycles.
- `paddr`/`pwrite`/`pwdata` hold their last values when `psel`=0.

## Timing
- Reset (`rst`=0, async): state IDLE; every output register cleared — `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_status` = 0, `busy`=0.
- `cmd_ready`=1 from the first cycle after reset release.
- Best case with `pclken`=1 and `pready`=1: handshake at cycle T; SETUP at T+1; ACCESS at T+2; `rsp_valid` at T+3.
- Next `cmd_ready` comes in the cycle after the `rsp_ready` handshake, so minimum period is 4 cycles per command.
- MISALIGNED: `rsp_valid` in cycle T+1.
- Each `pclken`=0 cycle stretches SETUP or ACCESS by one cycle.
- Reset asserted mid-transfer drops `psel`/`penable` immediately. The in-flight command is lost and no response is produced.
- All outputs are registered; there are no combinational paths from inputs to APB outputs.

## Structure
- Shared package `dma_apb_pkg`:
  - state enum
  - `rsp_status` enum (OK/SLVERR/TIMEOUT/MISALIGNED)
  - width constants `DMA_APB_ADDR_W`=13 and `DMA_APB_DATA_W`=32
- Single module. The timeout counter is inline; no sub-module is warranted.

## Test plan
- Write 0x0000_00A5 to 0x010 with `pready`=1 and `pclken`=1 -> SETUP one cycle, ACCESS one cycle with `paddr`=0x010, `pwdata`=0xA5; response status 00 and rdata 0 at T+3.
- Read 0x020 with `pready` low for 3 ACCESS cycles, then high with `prdata`=0xDEAD_BEEF -> 5-cycle transfer; rdata 0xDEADBEEF, status 00.
- Read with `pclken` toggling every other cycle and `pready`=1 -> phases advance only on enabled cycles; `psel` high 4 clk cycles.
- Write with `pslverr`=1 and `pready`=1 -> status 01; read with `pready` stuck low and TIMEOUT=16 -> abort after 16 enabled ACCESS cycles, status 10, `psel` drops.
- `cmd_addr`=0x013 -> no `psel` pulse; status 11 at T+1. Hold `rsp_ready`=0 for 5 cycles -> `cmd_ready` stays 0 and the response stays stable.
- Assert `rst` during ACCESS -> `psel`/`penable` low asynchronously; no `rsp_valid` after release.
